// File: rtl/pump_scheduler.sv
// Two-pump fill sequencer: lead/lag rotation, minimum run/off times,
// fault handling and sensor-inconsistency detection.
module pump_scheduler #(
    parameter int MIN_RUN = 4,
    parameter int MIN_OFF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic I,
    input  logic S,
    input  logic F1,
    input  logic F2,
    output logic B1,
    output logic B2,
    output logic LEAD,
    output logic ERR,
    output logic ALARM
);

    localparam int RW = $clog2(MIN_RUN + 1);
    localparam int OW = $clog2(MIN_OFF + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MIN_RUN);
    localparam logic [OW-1:0] OFF_MAX = OW'(MIN_OFF);

    typedef enum logic [1:0] {
        IDLE,
        FILL_ONE,
        FILL_BOTH,
        ERROR
    } state_t;

    state_t state, state_nx;

    logic [RW-1:0] run1, run2, run1_nx, run2_nx;
    logic [OW-1:0] off1, off2, off1_nx, off2_nx;
    logic          req1, req2;
    logic          b1_nx, b2_nx, lead_nx, err_nx, alarm_nx;
    logic          filling, filling_nx;

    always_comb begin
        state_nx = IDLE;
        if (S && !I)
            state_nx = ERROR;
        else if (S && I)
            state_nx = IDLE;
        else if (!I)
            state_nx = FILL_BOTH;
        else
            state_nx = FILL_ONE;
    end

    assign filling    = (state == FILL_ONE) || (state == FILL_BOTH);
    assign filling_nx = (state_nx == FILL_ONE) || (state_nx == FILL_BOTH);

    // In single-pump mode a faulted lead hands the request to the lag pump.
    always_comb begin
        req1 = 1'b0;
        req2 = 1'b0;
        if (state_nx == FILL_BOTH) begin
            req1 = 1'b1;
            req2 = 1'b1;
        end else if (state_nx == FILL_ONE) begin
            if (!LEAD)
                {req1, req2} = F1 ? 2'b01 : 2'b10;
            else
                {req1, req2} = F2 ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        b1_nx = 1'b0;
        if (F1 || state_nx == ERROR)
            b1_nx = 1'b0;
        else if (B1 && run1 < RUN_MAX)
            b1_nx = 1'b1;
        else if (req1 && (B1 || off1 >= OFF_MAX))
            b1_nx = 1'b1;
    end

    always_comb begin
        b2_nx = 1'b0;
        if (F2 || state_nx == ERROR)
            b2_nx = 1'b0;
        else if (B2 && run2 < RUN_MAX)
            b2_nx = 1'b1;
        else if (req2 && (B2 || off2 >= OFF_MAX))
            b2_nx = 1'b1;
    end

    // Counters include the cycle about to start, so a value of MIN_RUN
    // means the pump has already been on for MIN_RUN full cycles.
    always_comb begin
        run1_nx = '0;
        run2_nx = '0;
        off1_nx = '0;
        off2_nx = '0;
        if (b1_nx)
            run1_nx = !B1 ? RW'(1) : (run1 == RUN_MAX ? run1 : run1 + RW'(1));
        else
            off1_nx = B1 ? OW'(1) : (off1 == OFF_MAX ? off1 : off1 + OW'(1));
        if (b2_nx)
            run2_nx = !B2 ? RW'(1) : (run2 == RUN_MAX ? run2 : run2 + RW'(1));
        else
            off2_nx = B2 ? OW'(1) : (off2 == OFF_MAX ? off2 : off2 + OW'(1));
    end

    always_comb begin
        lead_nx  = LEAD ^ (filling && state_nx == IDLE);
        err_nx   = (state_nx == ERROR);
        alarm_nx = filling_nx && F1 && F2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            run1  <= '0;
            run2  <= '0;
            off1  <= OFF_MAX;
            off2  <= OFF_MAX;
            B1    <= 1'b0;
            B2    <= 1'b0;
            LEAD  <= 1'b0;
            ERR   <= 1'b0;
            ALARM <= 1'b0;
        end else begin
            state <= state_nx;
            run1  <= run1_nx;
            run2  <= run2_nx;
            off1  <= off1_nx;
            off2  <= off2_nx;
            B1    <= b1_nx;
            B2    <= b2_nx;
            LEAD  <= lead_nx;
            ERR   <= err_nx;
            ALARM <= alarm_nx;
        end
    end

endmodule

// File: tb/tb_pump_scheduler.sv
// Directed plus random stimulus for pump_scheduler, checked against a
// streak-based behavioural model of the pump rules.
module tb_pump_scheduler;

    localparam int MIN_RUN = 4;
    localparam int MIN_OFF = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic lvl_i = 1'b0;
    logic lvl_s = 1'b0;
    logic f1 = 1'b0;
    logic f2 = 1'b0;
    logic b1, b2, lead, err, alarm;

    int n_pass = 0;
    int n_chk = 0;
    int n_fail = 0;

    // Model: each pump is on/off with a count of consecutive cycles in that condition.
    bit m_on [2];
    int m_streak [2];
    bit m_lead, m_err, m_alarm, m_filling;

    pump_scheduler #(.MIN_RUN(MIN_RUN), .MIN_OFF(MIN_OFF)) dut (
        .clk(clk), .reset(reset), .I(lvl_i), .S(lvl_s), .F1(f1), .F2(f2),
        .B1(b1), .B2(b2), .LEAD(lead), .ERR(err), .ALARM(alarm)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_on[k] = 1'b0;
            m_streak[k] = MIN_OFF;
        end
        m_lead = 1'b0;
        m_err = 1'b0;
        m_alarm = 1'b0;
        m_filling = 1'b0;
    endfunction

    function automatic void model_edge(bit i, bit s, bit fa, bit fb);
        bit want [2];
        bit flt [2];
        bit serr, full, fill_now, nxt;
        int li;
        flt[0] = fa;
        flt[1] = fb;
        want[0] = 1'b0;
        want[1] = 1'b0;
        serr = s && !i;
        full = s && i;
        fill_now = !s;
        if (!s && !i) begin
            want[0] = 1'b1;
            want[1] = 1'b1;
        end else if (!s) begin
            li = int'(m_lead);
            if (flt[li]) li = 1 - li;
            want[li] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            nxt = !flt[k] && !serr &&
                  ((m_on[k] && m_streak[k] < MIN_RUN) ||
                   (want[k] && (m_on[k] || m_streak[k] >= MIN_OFF)));
            if (nxt == m_on[k]) m_streak[k]++;
            else m_streak[k] = 1;
            m_on[k] = nxt;
        end
        if (m_filling && full) m_lead = ~m_lead;
        m_filling = fill_now;
        m_err = serr;
        m_alarm = fill_now && fa && fb;
    endfunction

    task automatic check(input string tag, input logic act, input logic exp);
        n_chk++;
        assert (act === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at %0t: got %b expected %b", tag, $time, act, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".B1"}, b1, m_on[0]);
        check({ctx, ".B2"}, b2, m_on[1]);
        check({ctx, ".LEAD"}, lead, m_lead);
        check({ctx, ".ERR"}, err, m_err);
        check({ctx, ".ALARM"}, alarm, m_alarm);
    endtask

    task automatic step(input bit i, input bit s, input bit fa, input bit fb, input int n);
        for (int c = 0; c < n; c++) begin
            lvl_i = i;
            lvl_s = s;
            f1 = fa;
            f2 = fb;
            @(posedge clk);
            model_edge(i, s, fa, fb);
            #1;
            check_all("step");
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // fill both, then mid level, then full
        step(0, 0, 0, 0, 2);
        step(1, 0, 0, 0, 4);
        step(1, 1, 0, 0, 4);
        // LEAD=1: pump 2 leads, stopped early by full tank
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 5);
        // sensor error during fill-both
        step(0, 0, 0, 0, 2);
        step(0, 1, 0, 0, 2);
        step(1, 1, 0, 0, 3);
        // faults and alarm
        step(1, 0, 1, 0, 2);
        step(0, 0, 1, 1, 3);
        step(0, 0, 0, 0, 4);
        step(1, 1, 0, 0, 5);
        // restart under minimum-off hold
        step(1, 0, 0, 0, 5);
        step(1, 1, 0, 0, 4);
        step(1, 0, 0, 0, 4);

        // asynchronous reset mid-run, checked before the next edge
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // random level sequences with occasional faults
        for (int r = 0; r < 400; r++) begin
            bit ri, rs, ra, rb;
            int len;
            {rs, ri} = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0);
            rb = ($urandom_range(0, 7) == 0);
            len = $urandom_range(1, 6);
            step(ri, rs, ra, rb, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pump_scheduler.md
Name: pump_scheduler

Overview:
- Sequences the two fill pumps of the water tank from the lower level sensor I and the upper level sensor S.
- Decides how many pumps run, and which one: lead/lag rotation between fill cycles.
- Enforces minimum run and minimum off times on each pump, and handles pump faults and inconsistent sensor readings.
- Sits between the level sensors and the pump drive lines B1/B2, replacing a fixed sensor-to-pump mapping.

Parameters:
MIN_RUN, 4, minimum consecutive cycles a pump stays on once started (1..255)
MIN_OFF, 2, minimum consecutive cycles a pump stays off once stopped (1..255)

Ports:
clk    input   1  system clock, rising edge
reset  input   1  asynchronous, active-high reset
I      input   1  lower sensor, 1 = water at/above low mark
S      input   1  upper sensor, 1 = tank full
F1     input   1  pump 1 fault, 1 = pump 1 unavailable
F2     input   1  pump 2 fault, 1 = pump 2 unavailable
B1     output  1  pump 1 drive, registered
B2     output  1  pump 2 drive, registered
LEAD   output  1  lead pump select, 0 = pump 1, 1 = pump 2, registered
ERR    output  1  sensor inconsistency (S=1, I=0), registered
ALARM  output  1  demand present but no pump available, registered

Behaviour:
- Reset (async, any time, including mid-fill):
  - Outputs: B1=B2=0, LEAD=0, ERR=0, ALARM=0.
  - State: IDLE.
  - Run counters: 0. Off counters: preset to MIN_OFF, so pumps may start immediately after reset.
- All inputs are sampled on the rising clk edge. State, counters and outputs update on that same edge, so latency from input to output is 1 edge.
- States: IDLE, FILL_ONE, FILL_BOTH, ERROR.
- Next-state rules, in priority order, evaluated in every state:
  - S=1 & I=0 -> ERROR.
  - S=1 & I=1 -> IDLE.
  - S=0 & I=0 -> FILL_BOTH.
  - S=0 & I=1 -> FILL_ONE if the current state is FILL_BOTH or FILL_ONE; otherwise (IDLE, ERROR) -> FILL_ONE as well. Mid level always requests one pump.
- ERROR: ERR=1 and both pumps forced off immediately, ignoring MIN_RUN. Leaving ERROR follows the rules above; ERR clears on the same edge.
- Pump requests:
  - FILL_BOTH requests both pumps.
  - FILL_ONE requests the lead pump; if the lead pump is faulted, it requests the lag pump instead.
  - IDLE and ERROR request none.
- Next drive for pump k (k = 1, 2):
  - Forced 0 if Fk=1 or the next state is ERROR. This overrides MIN_RUN.
  - Else 1 if pump k is currently on and its run counter < MIN_RUN (minimum run hold).
  - Else 1 if pump k is requested and (it is currently on, or its off counter >= MIN_OFF).
  - Else 0.
- Run counter: counts cycles with Bk=1, saturates at MIN_RUN, clears when Bk goes 0.
- Off counter: counts cycles with Bk=0, saturates at MIN_OFF, clears when Bk goes 1.
- Counter width is the minimum needed for its saturation value.
- LEAD toggles on the edge where the state goes from FILL_ONE or FILL_BOTH into IDLE (one completed fill). No toggle on entry to ERROR.
- ALARM=1 when the next state is FILL_ONE or FILL_BOTH and F1=F2=1; otherwise 0. Pumps are off, per the fault override.
- A lag pump that is still in its minimum-run hold after FILL_BOTH -> FILL_ONE stays on until its run counter reaches MIN_RUN, then drops.
- Same rule applies to both pumps on entry to IDLE.
- If a pump's fault clears while it is requested and its off time is not yet met, the pump starts on the first edge where off counter >= MIN_OFF.
- Simultaneous events:
  - Fault on the lead pump together with entry into FILL_ONE: the lag pump is requested on that same edge.
  - Reset dominates everything.

Test Plan:
1. Apply reset=1, then release with I=0, S=0 -> while reset is high, B1=B2=LEAD=ERR=ALARM=0; on the first edge after release, B1=B2=1 (state FILL_BOTH).
2. After case 1 with pumps on for 2 cycles, set I=1 -> B1 stays 1, B2 stays 1 until its 4th run cycle, then B2=0; then set S=1 -> B1=0 once its run count >= 4, and LEAD becomes 1 on the IDLE-entry edge.
3. With LEAD=1, set S=0, I=1 -> B2=1, B1=0 next edge. Set S=1 after 1 cycle -> B2 held on 3 more cycles, then 0; LEAD returns to 0.
4. During FILL_BOTH, set I=0, S=1 -> ERR=1 and B1=B2=0 on the next edge regardless of run count. Then set I=1, S=1 -> ERR=0, state IDLE, pumps off.
5. LEAD=0, mid level, F1=1 -> B1=0, B2=1 next edge. Then set F2=1, I=0 -> ALARM=1, B1=B2=0. Clear both faults with I=0 -> ALARM=0 and pumps restart once their off counts reach 2.
6. Pump 1 stops (S=1 after min run), then immediately S=0, I=1 with LEAD=0 -> B1 stays 0 for 2 cycles, then B1=1. Assert reset mid-run -> all outputs 0 asynchronously, before the next clk edge.
